// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter and the transmitter it feeds.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE
    } arb_state_t;

    localparam int N_REQ_DEF       = 4;
    localparam int TIMEOUT_CYC_DEF = 8;

    // Parity-type encoding as understood by the transmitter.
    typedef enum logic {
        PAR_EVEN = 1'b0,
        PAR_ODD  = 1'b1
    } par_typ_t;

    function automatic int rr_wrap(input int idx, input int n);
        return idx % n;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Arbiter-to-transmitter link: byte, issue strobe, parity controls and the BUSY flag back.
interface uart_tx_arbiter_if;

    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       BUSY;

    modport master (
        output P_DATA,
        output DATA_VALID,
        output PAR_EN,
        output PAR_TYP,
        input  BUSY
    );

    modport slave (
        input  P_DATA,
        input  DATA_VALID,
        input  PAR_EN,
        input  PAR_TYP,
        output BUSY
    );

endinterface

// File: rtl/uart_rr_picker.sv
// Combinational round-robin select: first requester after last_grant, wrapping modulo N_REQ.
module uart_rr_picker
    import uart_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] last_grant,
    output logic                     vld,
    output logic [$clog2(N_REQ)-1:0] idx
);

    localparam int IDX_W = $clog2(N_REQ);

    logic [IDX_W-1:0] cand;

    // Scan from lowest to highest priority so the nearest pending requester wins.
    always_comb begin
        vld  = 1'b0;
        idx  = '0;
        cand = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = IDX_W'(rr_wrap(int'(last_grant) + k, N_REQ));
            if (req[cand]) begin
                vld = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte requesters.
// Optional BUSY watchdog enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ       = N_REQ_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [8*N_REQ-1:0]       req_data,
    input  logic                     par_en,
    input  logic                     par_typ,
    output logic [N_REQ-1:0]         ack,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    uart_tx_arbiter_if.master        tx,
    output logic                     frame_done,
    output logic                     timeout_err
);

    localparam int IDX_W = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("uart_tx_arbiter: N_REQ must be 2..8 and TIMEOUT_CYC at least 1");
    end

    arb_state_t       state;
    logic [IDX_W-1:0] last_grant;
    logic             pick_vld;
    logic [IDX_W-1:0] pick_idx;
    logic [7:0]       req_bytes [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_bytes
        assign req_bytes[g] = req_data[8*g +: 8];
    end

    uart_rr_picker #(.N_REQ(N_REQ)) u_picker (
        .req        (req),
        .last_grant (last_grant),
        .vld        (pick_vld),
        .idx        (pick_idx)
    );

`ifdef UART_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] to_cnt;
`else
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            last_grant    <= IDX_W'(N_REQ - 1);
            grant_id      <= '0;
            ack           <= '0;
            frame_done    <= 1'b0;
            tx.P_DATA     <= '0;
            tx.DATA_VALID <= 1'b0;
            tx.PAR_EN     <= 1'b0;
            tx.PAR_TYP    <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            to_cnt        <= '0;
            timeout_err   <= 1'b0;
`endif
        end else begin
            ack           <= '0;
            tx.DATA_VALID <= 1'b0;
            frame_done    <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            timeout_err   <= 1'b0;
`endif
            case (state)
                // A transmitter still busy from another source blocks the grant.
                IDLE: begin
                    if (pick_vld && !tx.BUSY) begin
                        tx.P_DATA  <= req_bytes[pick_idx];
                        tx.PAR_EN  <= par_en;
                        tx.PAR_TYP <= par_typ;
                        ack        <= N_REQ'(1) << pick_idx;
                        grant_id   <= pick_idx;
                        last_grant <= pick_idx;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    tx.DATA_VALID <= 1'b1;
                    state         <= WAIT_BUSY;
`ifdef UART_ARB_TIMEOUT_EN
                    to_cnt        <= '0;
`endif
                end
                WAIT_BUSY: begin
                    if (tx.BUSY) begin
                        state <= WAIT_DONE;
                    end
`ifdef UART_ARB_TIMEOUT_EN
                    // Abort quietly: last_grant keeps the aborted index, no frame_done.
                    else if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
`endif
                end
                WAIT_DONE: begin
                    if (!tx.BUSY) begin
                        frame_done <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized self-checking bench for uart_tx_arbiter with a behavioural transmitter and grant model.
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int N = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [N-1:0]       req = '0;
    logic [8*N-1:0]     req_data = '0;
    logic               par_en = 1'b0;
    logic               par_typ = 1'b0;
    logic [N-1:0]       ack;
    logic [$clog2(N)-1:0] grant_id;
    logic               frame_done;
    logic               timeout_err;

    int checks = 0;
    int failures = 0;
    int last_g = N - 1;
    int fd_seen = 0, exp_fd = 0;
    int to_seen = 0, exp_to = 0;
    logic [N-1:0] ack_seen = '0;

    always #5 clk = ~clk;

    uart_tx_arbiter_if tx();

    uart_tx_arbiter #(.N_REQ(N), .TIMEOUT_CYC(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_data    (req_data),
        .par_en      (par_en),
        .par_typ     (par_typ),
        .ack         (ack),
        .grant_id    (grant_id),
        .tx          (tx),
        .frame_done  (frame_done),
        .timeout_err (timeout_err)
    );

    // Transmitter model: BUSY rises two cycles after the DATA_VALID cycle, for 4..10 cycles.
    bit suppress = 1'b0;
    bit busy_r   = 1'b0;
    bit dv_d     = 1'b0;
    int len_cnt  = 0;

    always @(posedge clk) begin
        dv_d <= tx.DATA_VALID;
        if (dv_d && !suppress) begin
            busy_r  <= 1'b1;
            len_cnt <= $urandom_range(4, 10);
        end else if (len_cnt > 1) begin
            len_cnt <= len_cnt - 1;
        end else if (len_cnt == 1) begin
            len_cnt <= 0;
            busy_r  <= 1'b0;
        end
    end

    assign tx.BUSY = busy_r;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (frame_done)  fd_seen++;
        if (timeout_err) to_seen++;
        ack_seen = ack_seen | ack;
    endtask

    // Reference picker: first requester after the last grant, wrapping around.
    function automatic int rr_next(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++)
            if (r[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        last_g = N - 1;
    endtask

    task automatic do_frame(input int exp_id, input logic [N-1:0] req_after, input bit rst_mid);
        int n;
        logic [7:0] eb;
        logic epe, ept, pb;
        bit stray;
        eb  = req_data[8*exp_id +: 8];
        epe = par_en;
        ept = par_typ;
        n   = 0;
        pb  = tx.BUSY;
        while (ack == '0 && n < 300) begin
            pb = tx.BUSY;
            step();
            n++;
        end
        check_eq("grant_in_time", 64'(n < 300), 64'(1));
        if (n >= 300) return;
        check_eq("ack_onehot", 64'(ack), 64'(1) << exp_id);
        check_eq("grant_id", 64'(grant_id), 64'(exp_id));
        check_eq("p_data", 64'(tx.P_DATA), 64'(eb));
        check_eq("par_latched", 64'({tx.PAR_EN, tx.PAR_TYP}), 64'({epe, ept}));
        check_eq("no_grant_while_busy", 64'(pb), 64'(0));
        check_eq("dv_not_with_ack", 64'(tx.DATA_VALID), 64'(0));
        last_g  = exp_id;
        req     = req_after;
        par_en  = ~par_en;
        par_typ = ~par_typ;
        step();
        check_eq("dv_after_ack", 64'({tx.DATA_VALID, ack}), 64'({1'b1, {N{1'b0}}}));
        n = 0;
        stray = 1'b0;
        while (!tx.BUSY && n < 20) begin
            step();
            n++;
            stray |= tx.DATA_VALID | (|ack) | frame_done;
        end
        check_eq("busy_rise", 64'(n < 20), 64'(1));
        if (rst_mid) begin
            step();
            rst = 1'b0;
            step();
            check_eq("reset_mid_frame_outputs",
                     64'({ack, grant_id, tx.P_DATA, tx.DATA_VALID, tx.PAR_EN, tx.PAR_TYP,
                          frame_done, timeout_err}), 64'(0));
            rst = 1'b1;
            last_g = N - 1;
            return;
        end
        n = 0;
        while (tx.BUSY && n < 300) begin
            step();
            n++;
            stray |= tx.DATA_VALID | (|ack) | frame_done;
        end
        check_eq("busy_fall", 64'(n < 300), 64'(1));
        check_eq("no_early_done", 64'(frame_done), 64'(0));
        step();
        check_eq("frame_done_pulse", 64'(frame_done), 64'(1));
        check_eq("par_held", 64'({tx.PAR_EN, tx.PAR_TYP}), 64'({epe, ept}));
        check_eq("no_stray_strobe", 64'(stray), 64'(0));
        exp_fd++;
    endtask

    initial begin
        int e;
        logic [N-1:0] ra;

        // Reset values
        step();
        step();
        check_eq("reset_outputs",
                 64'({ack, grant_id, tx.P_DATA, tx.DATA_VALID, tx.PAR_EN, tx.PAR_TYP,
                      frame_done, timeout_err}), 64'(0));
        rst = 1'b1;
        step();

        // Single request
        req_data = 32'h0000_00A5;
        par_en = 1'b0;
        par_typ = 1'b0;
        req = 4'b0001;
        do_frame(0, 4'b0000, 1'b0);

        // All four held high: 0,1,2,3,0 then 1, then reset in the frame of 2
        do_reset();
        req_data = 32'h4030_2010;
        par_en = 1'b1;
        par_typ = 1'b1;
        req = 4'b1111;
        do_frame(0, 4'b1111, 1'b0);
        do_frame(1, 4'b1111, 1'b0);
        do_frame(2, 4'b1111, 1'b0);
        do_frame(3, 4'b1111, 1'b0);
        do_frame(0, 4'b1111, 1'b0);
        do_frame(1, 4'b1111, 1'b0);
        do_frame(2, 4'b1111, 1'b1);
        do_frame(0, 4'b1110, 1'b0);

        // Withdrawn request is skipped
        do_reset();
        req = 4'b0111;
        req_data = 32'hD4C3_B2A1;
        ack_seen = '0;
        do_frame(0, 4'b0101, 1'b0);
        do_frame(2, 4'b0000, 1'b0);
        check_eq("withdrawn_never_acked", 64'(ack_seen[1]), 64'(0));

`ifdef UART_ARB_TIMEOUT_EN
        begin
            int n;
            int fd0;
            fd0 = fd_seen;
            suppress = 1'b1;
            req = 4'b1000;
            n = 0;
            while (ack == '0 && n < 50) begin
                step();
                n++;
            end
            check_eq("to_grant", 64'(ack), 64'(4'b1000));
            req = 4'b0000;
            step();
            check_eq("to_dv", 64'(tx.DATA_VALID), 64'(1));
            n = 0;
            while (!timeout_err && n < 30) begin
                step();
                n++;
            end
            check_eq("timeout_cycles", 64'(n), 64'(8));
            exp_to++;
            step();
            check_eq("timeout_pulse_width", 64'(timeout_err), 64'(0));
            check_eq("no_done_on_abort", 64'(fd_seen), 64'(fd0));
            suppress = 1'b0;
            last_g = 3;
            req = 4'b1001;
            do_frame(rr_next(4'b1001, last_g), 4'b0000, 1'b0);
        end
`endif

        // Randomized traffic against the round-robin model
        for (int it = 0; it < 30; it++) begin
            req_data = $urandom;
            par_en = 1'($urandom);
            par_typ = 1'($urandom);
            if (req == '0) req[$urandom_range(0, N - 1)] = 1'b1;
            e = rr_next(req, last_g);
            ra = N'($urandom);
            do_frame(e, ra, 1'b0);
        end

        step();
        step();
        check_eq("frame_done_count", 64'(fd_seen), 64'(exp_fd));
        check_eq("timeout_err_count", 64'(to_seen), 64'(exp_to));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
